// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the transmitter frame controller.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    COMMIT  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OVERFLOW = 3'd1;
  localparam logic [2:0] ERR_EMPTY    = 3'd2;
  localparam logic [2:0] ERR_ABORT    = 3'd3;
  localparam logic [2:0] ERR_FAULT    = 3'd4;
  localparam logic [2:0] ERR_REFUSED  = 3'd5;

  localparam int TX_FAULT_BIT = 7;

endpackage

// File: rtl/tx_lowwater_irq.sv
// Sticky low-water interrupt: fires when the queued-frame count falls to or
// below LOW_WATER, held until acknowledged.
module tx_lowwater_irq #(
  parameter int LOW_WATER = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_count,
  input  logic       i_ack,
  output logic       o_irq
);

  localparam logic [7:0] LW = 8'(LOW_WATER);

  logic [7:0] cnt_q;
  logic       fall;

  assign fall = (cnt_q > LW) && (i_count <= LW);

  // A new crossing wins over an ack arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      o_irq <= 1'b0;
    end else begin
      cnt_q <= i_count;
      o_irq <= fall | (o_irq & ~i_ack);
    end
  end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Host-to-transmitter frame sequencer: opens, fills, commits or rolls back
// frames and resets the transmitter on a fault.
module tx_frame_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int MAX_FRAMES    = 8,
  parameter int MAX_FRAME_LEN = 1024,
  parameter int LOW_WATER     = 2,
  parameter int RST_CYCLES    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_host_start,
  input  logic [7:0]  i_host_data,
  input  logic        i_host_data_valid,
  input  logic        i_host_commit,
  input  logic        i_host_abort,
  input  logic        i_int_ack,
  output logic        o_host_ready,
  output logic        o_host_busy,
  output logic [2:0]  o_err,
  output logic        o_tx_int,
  output logic        o_tx_rst_n,
  output logic        o_tx_push_write_index,
  output logic        o_tx_pop_write_index,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_data_we,
  output logic        o_tx_push_frame,
  input  logic [15:0] i_tx_data_size,
  input  logic [7:0]  i_tx_frames_count,
  input  logic [7:0]  i_tx_status
);

  localparam int         CW     = $clog2(MAX_FRAME_LEN + 1);
  localparam int         RW     = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] LEN_MAX = CW'(MAX_FRAME_LEN);
  localparam logic [7:0] FR_MAX = 8'(MAX_FRAMES);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [RW-1:0] rst_cnt;
  logic          ready_q;
  logic          can_start;
  logic          fault;
  logic          unused_status;

  assign unused_status = ^{i_tx_data_size, i_tx_status[6:0]};

  // Acceptance uses the live count so a start right after a push sees it.
  assign can_start    = i_tx_frames_count < FR_MAX;
  assign fault        = i_tx_status[TX_FAULT_BIT];
  assign o_host_ready = ready_q && (state == IDLE);
  assign o_host_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      byte_cnt              <= '0;
      rst_cnt               <= '0;
      ready_q               <= 1'b0;
      o_err                 <= ERR_NONE;
      o_tx_rst_n            <= 1'b0;
      o_tx_push_write_index <= 1'b0;
      o_tx_pop_write_index  <= 1'b0;
      o_tx_data             <= '0;
      o_tx_data_we          <= 1'b0;
      o_tx_push_frame       <= 1'b0;
    end else begin
      o_tx_push_write_index <= 1'b0;
      o_tx_pop_write_index  <= 1'b0;
      o_tx_data_we          <= 1'b0;
      o_tx_push_frame       <= 1'b0;
      ready_q               <= can_start;

      // No pop on a fault: the transmitter reset clears its buffer anyway.
      if (fault && state != RECOVER) begin
        o_tx_rst_n <= 1'b0;
        rst_cnt    <= RST_LAST;
        o_err      <= ERR_FAULT;
        state      <= RECOVER;
      end else begin
        case (state)
          IDLE: begin
            o_tx_rst_n <= 1'b1;
            if (i_host_start) begin
              if (can_start) begin
                o_tx_push_write_index <= 1'b1;
                byte_cnt              <= '0;
                o_err                 <= ERR_NONE;
                state                 <= OPEN;
              end else begin
                o_err <= ERR_REFUSED;
              end
            end
          end
          OPEN: begin
            if (i_host_abort) begin
              o_tx_pop_write_index <= 1'b1;
              o_err                <= ERR_ABORT;
              state                <= IDLE;
            end else if (i_host_data_valid && byte_cnt == LEN_MAX) begin
              o_tx_pop_write_index <= 1'b1;
              o_err                <= ERR_OVERFLOW;
              state                <= IDLE;
            end else begin
              if (i_host_data_valid) begin
                o_tx_data    <= i_host_data;
                o_tx_data_we <= 1'b1;
                byte_cnt     <= byte_cnt + 1'b1;
              end
              if (i_host_commit) state <= COMMIT;
            end
          end
          COMMIT: begin
            if (byte_cnt == '0) begin
              o_tx_pop_write_index <= 1'b1;
              o_err                <= ERR_EMPTY;
            end else begin
              o_tx_push_frame <= 1'b1;
            end
            state <= IDLE;
          end
          RECOVER: begin
            if (rst_cnt == '0) begin
              o_tx_rst_n <= 1'b1;
              state      <= IDLE;
            end else begin
              rst_cnt <= rst_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  tx_lowwater_irq #(
    .LOW_WATER (LOW_WATER)
  ) u_irq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_count (i_tx_frames_count),
    .i_ack   (i_int_ack),
    .o_irq   (o_tx_int)
  );

endmodule
